edh_axi_burst_engine: RTL

Parametrised AXI4 burst master that moves one command's worth of beats between DRAM and a valid/ready stream on the core side. It is the next generation of the EDH DRAM access path: data width, address width, ID and burst length are generic, and it supports both read and write modes. It also adds response/`rlast` error checking and 4 KB-boundary protection. It sits between an EDH-class compute core (picture/SE loader and write-back) and the AXI4 DRAM slave.

---
 rtl/edh_axi_pkg.sv | 28 ++
 rtl/edh_axi_burst_engine.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/edh_axi_pkg.sv
// Shared types and constants for the EDH AXI4 burst engine.
// Holds the AXI encodings, the engine state type and the beat-size helper.
package edh_axi_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    StIdle,
    StAr,
    StR,
    StAw,
    StW,
    StB,
    StDone
  } axi_eng_state_t;

  // AXI size field: log2 of the bytes per beat.
  function automatic logic [2:0] size_of(int unsigned data_width);
    logic [2:0] s;
    s = '0;
    for (int unsigned b = data_width / 8; b > 1; b = b / 2) begin
      s = s + 3'd1;
    end
    return s;
  endfunction

endpackage

// File: rtl/edh_axi_burst_engine.sv
// Single-command AXI4 burst master: moves cmd_len beats between DRAM and a
// valid/ready stream, flagging bad responses, rlast mismatches and 4 KB crossings.
module edh_axi_burst_engine
  import edh_axi_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned MAX_LEN    = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [8:0]            cmd_len,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  done,
  output logic                  err,
  output logic [ID_WIDTH-1:0]   awid_m_inf,
  output logic [ADDR_WIDTH-1:0] awaddr_m_inf,
  output logic [7:0]            awlen_m_inf,
  output logic [2:0]            awsize_m_inf,
  output logic [1:0]            awburst_m_inf,
  output logic                  awvalid_m_inf,
  input  logic                  awready_m_inf,
  output logic [DATA_WIDTH-1:0] wdata_m_inf,
  output logic                  wlast_m_inf,
  output logic                  wvalid_m_inf,
  input  logic                  wready_m_inf,
  input  logic [ID_WIDTH-1:0]   bid_m_inf,
  input  logic [1:0]            bresp_m_inf,
  input  logic                  bvalid_m_inf,
  output logic                  bready_m_inf,
  output logic [ID_WIDTH-1:0]   arid_m_inf,
  output logic [ADDR_WIDTH-1:0] araddr_m_inf,
  output logic [7:0]            arlen_m_inf,
  output logic [2:0]            arsize_m_inf,
  output logic [1:0]            arburst_m_inf,
  output logic                  arvalid_m_inf,
  input  logic                  arready_m_inf,
  input  logic [ID_WIDTH-1:0]   rid_m_inf,
  input  logic [DATA_WIDTH-1:0] rdata_m_inf,
  input  logic [1:0]            rresp_m_inf,
  input  logic                  rlast_m_inf,
  input  logic                  rvalid_m_inf,
  output logic                  rready_m_inf
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam logic [2:0]  SIZE  = size_of(DATA_WIDTH);

  axi_eng_state_t        state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [8:0]            len_q, len_d;
  logic [8:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic [31:0] span;
  logic        bad_cmd;
  logic        last_beat;
  logic [7:0]  burst_len;

  // Bytes from the start of the 4 KB page to the end of the burst.
  assign span      = 32'(cmd_addr[11:0]) + 32'(cmd_len) * BYTES;
  assign bad_cmd   = (cmd_len == 9'd0) || (32'(cmd_len) > MAX_LEN) || (span > 32'd4096);
  assign last_beat = (cnt_q == len_q - 9'd1);
  assign burst_len = 8'(len_q - 9'd1);

  assign awid_m_inf = '0;
  assign arid_m_inf = '0;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    cmd_ready     = 1'b0;
    out_valid     = 1'b0;
    out_data      = '0;
    in_ready      = 1'b0;
    done          = 1'b0;
    err           = 1'b0;
    awaddr_m_inf  = '0;
    awlen_m_inf   = '0;
    awsize_m_inf  = '0;
    awburst_m_inf = '0;
    awvalid_m_inf = 1'b0;
    wdata_m_inf   = '0;
    wlast_m_inf   = 1'b0;
    wvalid_m_inf  = 1'b0;
    bready_m_inf  = 1'b0;
    araddr_m_inf  = '0;
    arlen_m_inf   = '0;
    arsize_m_inf  = '0;
    arburst_m_inf = '0;
    arvalid_m_inf = 1'b0;
    rready_m_inf  = 1'b0;

    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d = cmd_addr;
          len_d  = cmd_len;
          cnt_d  = '0;
          err_d  = bad_cmd;
          if (bad_cmd) begin
            state_d = StDone;
          end else if (cmd_wr) begin
            state_d = StAw;
          end else begin
            state_d = StAr;
          end
        end
      end
      StAr: begin
        araddr_m_inf  = addr_q;
        arlen_m_inf   = burst_len;
        arsize_m_inf  = SIZE;
        arburst_m_inf = BURST_INCR;
        arvalid_m_inf = 1'b1;
        if (arready_m_inf) state_d = StR;
      end
      StR: begin
        out_valid    = rvalid_m_inf;
        out_data     = rdata_m_inf;
        rready_m_inf = out_ready;
        if (rvalid_m_inf && out_ready) begin
          cnt_d = cnt_q + 9'd1;
          // A foreign ID is treated like any other bad response.
          if (rresp_m_inf != RESP_OKAY || rid_m_inf != '0 || rlast_m_inf != last_beat) begin
            err_d = 1'b1;
          end
          if (last_beat) state_d = StDone;
        end
      end
      StAw: begin
        awaddr_m_inf  = addr_q;
        awlen_m_inf   = burst_len;
        awsize_m_inf  = SIZE;
        awburst_m_inf = BURST_INCR;
        awvalid_m_inf = 1'b1;
        if (awready_m_inf) state_d = StW;
      end
      StW: begin
        wvalid_m_inf = in_valid;
        wdata_m_inf  = in_data;
        wlast_m_inf  = last_beat;
        in_ready     = wready_m_inf;
        if (in_valid && wready_m_inf) begin
          cnt_d = cnt_q + 9'd1;
          if (last_beat) state_d = StB;
        end
      end
      StB: begin
        bready_m_inf = 1'b1;
        if (bvalid_m_inf) begin
          if (bresp_m_inf != RESP_OKAY || bid_m_inf != '0) err_d = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        err     = err_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule
